// File: rtl/exc_ctrl_pkg.sv
// Shared cp0 definitions: exccodes, mem_exc_flags bit indices, exception vector, FSM/encoder types.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;
  localparam int unsigned NUM_IRQ_BITS = 8;

  localparam logic [4:0] EXC_Int  = 5'd0;
  localparam logic [4:0] EXC_AdEL = 5'd4;
  localparam logic [4:0] EXC_AdES = 5'd5;
  localparam logic [4:0] EXC_Sys  = 5'd8;
  localparam logic [4:0] EXC_Bp   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_Ov   = 5'd12;
  // Pseudo-codes in the reserved exccode range, understood only by cp0.
  localparam logic [4:0] ERET     = 5'd16;
  localparam logic [4:0] REFETCH  = 5'd17;

  localparam int unsigned FLAG_FETCH_ADEL = 0;
  localparam int unsigned FLAG_RI         = 1;
  localparam int unsigned FLAG_OV         = 2;
  localparam int unsigned FLAG_SYS        = 3;
  localparam int unsigned FLAG_BP         = 4;
  localparam int unsigned FLAG_DATA_ADEL  = 5;
  localparam int unsigned FLAG_DATA_ADES  = 6;
  localparam int unsigned FLAG_ERET       = 7;
  localparam int unsigned FLAG_REFETCH    = 8;
  localparam int unsigned NUM_EXC_FLAGS   = 9;

  typedef enum logic [1:0] {BvNone, BvFetch, BvData} bv_sel_e;
  typedef enum logic [1:0] {KindExc, KindInt, KindEret, KindRefetch} kind_e;
  typedef enum logic {StIdle, StRedirect} state_e;

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Fixed-priority encoder from {int_pending, exception flags} to the single event to report.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic                     int_pending,
  input  logic [NUM_EXC_FLAGS-1:0] flags,
  output logic                     hit,
  output logic [4:0]               exccode,
  output bv_sel_e                  badvaddr_sel,
  output kind_e                    kind
);

  always_comb begin
    hit          = 1'b1;
    exccode      = EXC_Int;
    badvaddr_sel = BvNone;
    kind         = KindExc;
    if (int_pending) begin
      kind = KindInt;
    end else if (flags[FLAG_FETCH_ADEL]) begin
      exccode      = EXC_AdEL;
      badvaddr_sel = BvFetch;
    end else if (flags[FLAG_RI]) begin
      exccode = EXC_RI;
    end else if (flags[FLAG_OV]) begin
      exccode = EXC_Ov;
    end else if (flags[FLAG_SYS]) begin
      exccode = EXC_Sys;
    end else if (flags[FLAG_BP]) begin
      exccode = EXC_Bp;
    end else if (flags[FLAG_DATA_ADEL]) begin
      exccode      = EXC_AdEL;
      badvaddr_sel = BvData;
    end else if (flags[FLAG_DATA_ADES]) begin
      exccode      = EXC_AdES;
      badvaddr_sel = BvData;
    end else if (flags[FLAG_ERET]) begin
      exccode = ERET;
      kind    = KindEret;
    end else if (flags[FLAG_REFETCH]) begin
      exccode = REFETCH;
      kind    = KindRefetch;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter and fetch redirect controller at MEM/commit.
// Optional event counters enabled by EXC_CTRL_STATS_EN.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = exc_ctrl_pkg::EXC_VECTOR,
  parameter int unsigned NUM_IRQ_BITS = exc_ctrl_pkg::NUM_IRQ_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_pc,
  input  logic                    mem_is_delay_slot,
  input  logic [8:0]              mem_exc_flags,
  input  logic [31:0]             mem_fetch_badvaddr,
  input  logic [31:0]             mem_data_badvaddr,
  input  logic [NUM_IRQ_BITS-1:0] cp0_cause_ip,
  input  logic [NUM_IRQ_BITS-1:0] cp0_status_im,
  input  logic                    cp0_status_ie,
  input  logic                    cp0_status_exl,
  input  logic [31:0]             cp0_epc,
  output logic                    cp0_exception_like,
  output logic [4:0]              cp0_exccode,
  output logic [31:0]             cp0_pc,
  output logic                    cp0_is_delay_slot,
  output logic [31:0]             cp0_badvaddr,
  output logic                    commit_kill,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  input  logic                    redirect_ready
`ifdef EXC_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_exc_count,
  output logic [31:0]             stat_int_count
`endif
);

  import exc_ctrl_pkg::*;

  logic        int_pending;
  logic        hit;
  logic        evt;
  logic [4:0]  enc_code;
  bv_sel_e     bv_sel;
  kind_e       kind;
  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;

  assign int_pending = (|(cp0_cause_ip & cp0_status_im)) & cp0_status_ie & ~cp0_status_exl;
  assign evt         = mem_valid & hit;

  exc_prio_enc u_prio_enc (
    .int_pending  (int_pending),
    .flags        (mem_exc_flags),
    .hit          (hit),
    .exccode      (enc_code),
    .badvaddr_sel (bv_sel),
    .kind         (kind)
  );

  always_comb begin
    state_d            = state_q;
    target_d           = target_q;
    cp0_exception_like = 1'b0;
    commit_kill        = 1'b0;
    flush              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = target_q;
    cp0_exccode        = enc_code;
    cp0_pc             = mem_pc;
    cp0_is_delay_slot  = mem_is_delay_slot;
    unique case (bv_sel)
      BvFetch: cp0_badvaddr = mem_fetch_badvaddr;
      BvData:  cp0_badvaddr = mem_data_badvaddr;
      default: cp0_badvaddr = 32'h0;
    endcase
    // Outputs are gated during reset so a pending event cannot leak a strobe.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (evt) begin
            cp0_exception_like = 1'b1;
            commit_kill        = 1'b1;
            flush              = 1'b1;
            state_d            = StRedirect;
            unique case (kind)
              KindEret:    target_d = cp0_epc;
              KindRefetch: target_d = mem_pc + 32'd4;
              default:     target_d = EXC_VECTOR;
            endcase
          end
        end
        StRedirect: begin
          redirect_valid = 1'b1;
          flush          = 1'b1;
          if (redirect_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef EXC_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_exc_count <= 32'h0;
      stat_int_count <= 32'h0;
    end else if (state_q == StIdle && evt) begin
      if (kind == KindInt) stat_int_count <= stat_int_count + 32'd1;
      else if (kind == KindExc) stat_exc_count <= stat_exc_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized and directed bench for exc_ctrl against an in-bench behavioural model.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_is_delay_slot;
  logic [8:0]  mem_exc_flags;
  logic [31:0] mem_fetch_badvaddr;
  logic [31:0] mem_data_badvaddr;
  logic [7:0]  cp0_cause_ip;
  logic [7:0]  cp0_status_im;
  logic        cp0_status_ie;
  logic        cp0_status_exl;
  logic [31:0] cp0_epc;
  logic        cp0_exception_like;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_pc;
  logic        cp0_is_delay_slot;
  logic [31:0] cp0_badvaddr;
  logic        commit_kill;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
`ifdef EXC_CTRL_STATS_EN
  logic [31:0] stat_exc_count;
  logic [31:0] stat_int_count;
`endif

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .mem_valid          (mem_valid),
    .mem_pc             (mem_pc),
    .mem_is_delay_slot  (mem_is_delay_slot),
    .mem_exc_flags      (mem_exc_flags),
    .mem_fetch_badvaddr (mem_fetch_badvaddr),
    .mem_data_badvaddr  (mem_data_badvaddr),
    .cp0_cause_ip       (cp0_cause_ip),
    .cp0_status_im      (cp0_status_im),
    .cp0_status_ie      (cp0_status_ie),
    .cp0_status_exl     (cp0_status_exl),
    .cp0_epc            (cp0_epc),
    .cp0_exception_like (cp0_exception_like),
    .cp0_exccode        (cp0_exccode),
    .cp0_pc             (cp0_pc),
    .cp0_is_delay_slot  (cp0_is_delay_slot),
    .cp0_badvaddr       (cp0_badvaddr),
    .commit_kill        (commit_kill),
    .flush              (flush),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .redirect_ready     (redirect_ready)
`ifdef EXC_CTRL_STATS_EN
    ,
    .stat_exc_count     (stat_exc_count),
    .stat_int_count     (stat_int_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flags are priority-ordered by bit index, so the lowest set bit wins after Int.
  logic [4:0]  code_tbl [9] = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5, ERET, REFETCH};
  bit          m_busy   = 1'b0;
  logic [31:0] m_target = 32'h0;
  int unsigned m_exc    = 0;
  int unsigned m_int    = 0;

  function automatic int first_event(input logic int_p, input logic [8:0] f);
    if (int_p) return -1;
    for (int i = 0; i < 9; i++) if (f[i]) return i;
    return 9;
  endfunction

  function automatic logic m_int_p();
    return (|(cp0_cause_ip & cp0_status_im)) && cp0_status_ie && !cp0_status_exl;
  endfunction

  function automatic logic [31:0] target_of(input int e);
    if (e == 7) return cp0_epc;
    if (e == 8) return mem_pc + 32'd4;
    return 32'hBFC00380;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_target <= 32'h0;
      m_exc    <= 0;
      m_int    <= 0;
    end else if (m_busy) begin
      if (redirect_ready) m_busy <= 1'b0;
    end else if (mem_valid && first_event(m_int_p(), mem_exc_flags) != 9) begin
      m_busy   <= 1'b1;
      m_target <= target_of(first_event(m_int_p(), mem_exc_flags));
      if (first_event(m_int_p(), mem_exc_flags) == -1) m_int <= m_int + 1;
      else if (first_event(m_int_p(), mem_exc_flags) < 7) m_exc <= m_exc + 1;
    end
  end

  always @(negedge clk) begin : compare
    automatic int   e      = first_event(m_int_p(), mem_exc_flags);
    automatic logic strobe = !reset && !m_busy && mem_valid && (e != 9);
    automatic logic busy   = !reset && m_busy;
    automatic logic [31:0] bv;
    chk("exception_like", {31'b0, cp0_exception_like}, {31'b0, strobe});
    chk("commit_kill", {31'b0, commit_kill}, {31'b0, strobe});
    chk("flush", {31'b0, flush}, {31'b0, strobe | busy});
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, busy});
    if (strobe) begin
      bv = (e == 0) ? mem_fetch_badvaddr : ((e == 5 || e == 6) ? mem_data_badvaddr : 32'h0);
      chk("exccode", {27'b0, cp0_exccode}, {27'b0, (e < 0) ? 5'd0 : code_tbl[e]});
      chk("badvaddr", cp0_badvaddr, bv);
      chk("cp0_pc", cp0_pc, mem_pc);
      chk("delay_slot", {31'b0, cp0_is_delay_slot}, {31'b0, mem_is_delay_slot});
    end
    if (busy) chk("redirect_pc", redirect_pc, m_target);
`ifdef EXC_CTRL_STATS_EN
    chk("stat_exc", stat_exc_count, m_exc);
    chk("stat_int", stat_int_count, m_int);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic quiet();
    mem_valid      = 1'b0;
    mem_exc_flags  = 9'h0;
    cp0_cause_ip   = 8'h0;
    cp0_status_im  = 8'h0;
    cp0_status_ie  = 1'b0;
    cp0_status_exl = 1'b0;
    redirect_ready = 1'b0;
  endtask

  // Consume the strobe cycle, then accept the redirect on its first cycle.
  task automatic finish_redirect();
    step();
    quiet();
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    mem_pc             = 32'h0;
    mem_is_delay_slot  = 1'b0;
    mem_fetch_badvaddr = 32'h0;
    mem_data_badvaddr  = 32'h0;
    cp0_epc            = 32'h0;
    quiet();
    step();
    step();
    reset = 1'b0;
    settle();
    chk("rst_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'd0);

    // Overflow: strobe, then held redirect to the vector until accepted.
    step();
    mem_valid = 1'b1; mem_exc_flags = 9'h004; mem_pc = 32'h80001000;
    settle();
    chk("ov_strobe", {31'b0, cp0_exception_like}, 32'd1);
    chk("ov_code", {27'b0, cp0_exccode}, 32'd12);
    chk("ov_kill", {31'b0, commit_kill}, 32'd1);
    step();
    quiet();
    settle();
    chk("ov_rvalid", {31'b0, redirect_valid}, 32'd1);
    chk("ov_rpc", redirect_pc, 32'hBFC00380);
    step();
    redirect_ready = 1'b1;
    settle();
    chk("ov_hold", {31'b0, redirect_valid}, 32'd1);
    step();
    redirect_ready = 1'b0;
    settle();
    chk("ov_idle", {31'b0, redirect_valid}, 32'd0);

    // RI beats Sys and data AdES, and carries no bad address.
    step();
    mem_valid = 1'b1; mem_exc_flags = 9'h04A; mem_data_badvaddr = 32'h12345678;
    settle();
    chk("ri_code", {27'b0, cp0_exccode}, 32'd10);
    chk("ri_bv", cp0_badvaddr, 32'h0);
    finish_redirect();

    // Interrupt beats ERET; with EXL=1 the ERET is taken instead.
    mem_valid = 1'b1; mem_exc_flags = 9'h080; cp0_epc = 32'h80002004;
    cp0_cause_ip = 8'h80; cp0_status_im = 8'h80; cp0_status_ie = 1'b1;
    settle();
    chk("int_code", {27'b0, cp0_exccode}, 32'd0);
    finish_redirect();
    mem_valid = 1'b1; mem_exc_flags = 9'h080;
    cp0_cause_ip = 8'h80; cp0_status_im = 8'h80; cp0_status_ie = 1'b1; cp0_status_exl = 1'b1;
    settle();
    chk("eret_code", {27'b0, cp0_exccode}, {27'b0, ERET});
    step();
    quiet();
    settle();
    chk("eret_rpc", redirect_pc, 32'h80002004);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;

    // Data AdEL address, then fetch AdEL address wins when both are flagged.
    mem_valid = 1'b1; mem_exc_flags = 9'h020; mem_data_badvaddr = 32'h80000003;
    settle();
    chk("dadel_code", {27'b0, cp0_exccode}, 32'd4);
    chk("dadel_bv", cp0_badvaddr, 32'h80000003);
    finish_redirect();
    mem_valid = 1'b1; mem_exc_flags = 9'h021; mem_fetch_badvaddr = 32'h80000001;
    settle();
    chk("fadel_bv", cp0_badvaddr, 32'h80000001);
    finish_redirect();

    // Interrupt without a valid instruction is not taken.
    cp0_cause_ip = 8'h01; cp0_status_im = 8'h01; cp0_status_ie = 1'b1;
    settle();
    chk("int_novalid", {31'b0, cp0_exception_like}, 32'd0);
    quiet();

    // REFETCH wraps; held redirect ignores a new event; reset drops it.
    mem_valid = 1'b1; mem_exc_flags = 9'h100; mem_pc = 32'hFFFFFFFC;
    step();
    mem_exc_flags = 9'h004;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hold_rpc", redirect_pc, 32'h0);
      chk("hold_valid", {31'b0, redirect_valid}, 32'd1);
      chk("hold_nostrobe", {31'b0, cp0_exception_like}, 32'd0);
      step();
    end
    reset = 1'b1;
    settle();
    chk("midrst_valid", {31'b0, redirect_valid}, 32'd0);
    chk("midrst_flush", {31'b0, flush}, 32'd0);
    chk("midrst_kill", {31'b0, commit_kill}, 32'd0);
    chk("midrst_strobe", {31'b0, cp0_exception_like}, 32'd0);
    step();
    reset = 1'b0;
    quiet();
    settle();
    chk("postrst_pc", redirect_pc, 32'h0);
    chk("postrst_valid", {31'b0, redirect_valid}, 32'd0);

    // Random traffic checked cycle by cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset              = ($urandom_range(0, 99) == 0);
      mem_valid          = $urandom_range(0, 1);
      mem_pc             = $urandom;
      mem_is_delay_slot  = $urandom_range(0, 1);
      mem_fetch_badvaddr = $urandom;
      mem_data_badvaddr  = $urandom;
      cp0_epc            = $urandom;
      cp0_cause_ip       = 8'($urandom);
      cp0_status_im      = 8'($urandom);
      cp0_status_ie      = ($urandom_range(0, 3) == 0);
      cp0_status_exl     = $urandom_range(0, 1);
      redirect_ready     = $urandom_range(0, 1);
      for (int b = 0; b < 9; b++) mem_exc_flags[b] = ($urandom_range(0, 9) == 0);
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt arbiter and redirect controller in the MEM/commit stage, directly upstream of cp0.
- Collects per-instruction exception flags and the pending-interrupt condition, and selects one event by fixed priority.
- Drives cp0's one-cycle exception_like/exccode/pc/badvaddr strobe for that event.
- Flushes the pipeline, then holds a redirect request to fetch until fetch accepts it.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry (BEV=1).
- NUM_IRQ_BITS, 8, width of cause IP / status IM fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  32  PC of the MEM instruction
- mem_is_delay_slot  in  1  MEM instruction is in a branch delay slot
- mem_exc_flags  in  9  [0]fetch AdEL, [1]RI, [2]Ov, [3]Sys, [4]Bp, [5]data AdEL, [6]data AdES, [7]ERET, [8]REFETCH
- mem_fetch_badvaddr  in  32  faulting fetch address
- mem_data_badvaddr  in  32  faulting load/store address
- cp0_cause_ip  in  8  cause.IP from cp0
- cp0_status_im  in  8  status.IM
- cp0_status_ie  in  1  status.IE
- cp0_status_exl  in  1  status.EXL
- cp0_epc  in  32  EPC, used as the ERET target
- cp0_exception_like  out  1  one-cycle event strobe to cp0
- cp0_exccode  out  5  exccode, ERET or REFETCH code
- cp0_pc  out  32  mem_pc passthrough
- cp0_is_delay_slot  out  1  passthrough
- cp0_badvaddr  out  32  selected bad address
- commit_kill  out  1  suppresses MEM-stage memory write and regfile write
- flush  out  1  invalidates IF..MEM stage registers
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- int_pending = |(cp0_cause_ip & cp0_status_im) & cp0_status_ie & ~cp0_status_exl.
- event = mem_valid & (int_pending | |mem_exc_flags).
- Priority, high to low: Int(0), fetch AdEL(4), RI(10), Ov(12), Sys(8), Bp(9), data AdEL(4), data AdES(5), ERET, REFETCH. Exactly one event is encoded.
- badvaddr selection:
  - fetch AdEL -> mem_fetch_badvaddr.
  - data AdEL/AdES -> mem_data_badvaddr.
  - otherwise 0.
- FSM states: IDLE, REDIRECT.
- IDLE:
  - When event is true, all of the following are asserted combinationally in that same cycle: cp0_exception_like=1, commit_kill=1, flush=1.
  - The target is registered: exception -> EXC_VECTOR; ERET -> cp0_epc (sampled this cycle); REFETCH -> mem_pc+4 (32-bit wrap).
  - Next state REDIRECT.
- REDIRECT:
  - redirect_valid=1, flush=1, and redirect_pc is held stable.
  - cp0_exception_like=0; new events are ignored because MEM is flushed.
  - When redirect_ready=1 -> IDLE. redirect_valid must not drop before acceptance.
- Minimum event-to-event spacing is 2 cycles: strobe cycle, then at least 1 REDIRECT cycle.
- If redirect_ready is already 1 on the first REDIRECT cycle, return to IDLE next cycle.
- Reset, including mid-REDIRECT:
  - state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, commit_kill=0, cp0_exception_like=0.
  - A pending redirect is dropped.
- Interrupt with mem_valid=0 is not taken; it waits for a valid instruction.
- Interrupt and ERET on the same instruction: Int wins, and EPC becomes the ERET's PC.
- An exception while EXL=1 still vectors to EXC_VECTOR. cp0 preserves EPC in that case.
- ERET and REFETCH carry no badvaddr and cause no EXL change here; cp0 handles EXL.

Optional Feature:
- Macro EXC_CTRL_STATS_EN.
- When defined:
  - Adds outputs stat_exc_count[31:0] and stat_int_count[31:0].
  - Counters increment on each IDLE event strobe: Int -> int counter; other exceptions -> exc counter; ERET/REFETCH -> neither.
  - Counters reset to 0 and wrap at 2^32.
- When undefined: neither the ports nor the counters exist.

Decomposition:
- The shared cp0 header holds exccode constants (EXC_Int, EXC_AdEL, EXC_AdES, EXC_Sys, EXC_Bp, EXC_RI, EXC_Ov, ERET, REFETCH), the mem_exc_flags bit indices, and EXC_VECTOR.
- Sub-module exc_prio_enc: purely combinational priority encoder from {int_pending, flags} to {hit, exccode, badvaddr_sel, kind}.

Test Plan:
- mem_valid=1, flags[2] (Ov), mem_pc=0x80001000 -> 1-cycle strobe with exccode=12, commit_kill=1. Next cycle redirect_valid=1 with pc=0xBFC00380. Held until redirect_ready, then IDLE.
- flags[1]|flags[3]|flags[6] together -> exccode=10 (RI), badvaddr=0.
- IE=1, EXL=0, IP[7]=IM[7]=1 alongside flags[7] (ERET) -> exccode=0. Repeat with EXL=1 -> exccode=ERET, redirect_pc=cp0_epc=0x80002004.
- flags[5] with data_badvaddr=0x80000003 -> exccode=4, badvaddr=0x80000003. Same with flags[0] and fetch_badvaddr=0x80000001 -> fetch address wins.
- REFETCH at mem_pc=0xFFFFFFFC -> redirect_pc=0x00000000. Hold redirect_ready=0 for 5 cycles -> redirect_valid and pc stable and a new flag is ignored; assert reset mid-hold -> all outputs 0, IDLE.
- EXC_CTRL_STATS_EN: 3 Ov, 2 Int, 1 ERET events -> stat_exc_count=3, stat_int_count=2.
